imem_sync: RTL and testbench
============================

Name: imem_sync

Overview:
- Parametrised synchronous instruction memory for the single-cycle/multicycle MIPS datapath.
- Stores bytes little-endian: byte at addr is bits [7:0], addr+3 is bits [31:24].
- Instruction fetch uses a valid/ready request/response handshake with 1-cycle latency.
- A loader port with a LOAD mode lets the bench or boot logic program memory at run time.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 4.
- ADDR_W, 32, address width of the fetch and loader ports.
- WORD_BYTES, 4, bytes per instruction word; data width = 8*WORD_BYTES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when req_valid && req_ready.
- req_addr  in  ADDR_W  byte address of the instruction word.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8*WORD_BYTES  instruction word, little-endian assembled.
- rsp_err  out  1  request was misaligned or out of range.
- ld_req  in  1  request LOAD mode.
- ld_ack  out  1  high while in LOAD state.
- ld_we  in  1  loader word write strobe.
- ld_be  in  WORD_BYTES  byte enables, bit i writes byte addr+i.
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  8*WORD_BYTES  loader write data.
- ld_err  out  1  one-cycle pulse when a write is rejected.
- fetch_cnt  out  32  count of accepted fetches; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (synchronous, active-high): state=FETCH; rsp_valid=0, rsp_data=0, rsp_err=0, ld_ack=0, ld_err=0, fetch_cnt=0. Memory contents are not reset.
- FSM states:
  - FETCH: req_ready = !rsp_valid || rsp_ready. If ld_req=1 and no response is pending (or it is consumed this cycle), go to LOAD. If ld_req=1 and a response is pending, go to DRAIN. req_ready=0 in any cycle where ld_req=1.
  - DRAIN: req_ready=0. Go to LOAD when rsp_valid=0 or in the cycle rsp_ready=1. If ld_req drops first, return to FETCH.
  - LOAD: ld_ack=1, req_ready=0. ld_req=0 returns to FETCH the next cycle; ld_ack falls with the state change.
- Fetch latency:
  - A request accepted at edge N gives rsp_valid=1 after edge N.
  - The response is held stable until rsp_ready=1.
  - Back-to-back requests sustain 1 word per cycle while rsp_ready=1.
- Error check:
  - Error if req_addr % WORD_BYTES != 0, or req_addr > DEPTH_BYTES - WORD_BYTES (all ADDR_W bits compared, no wrap).
  - On error: rsp_err=1 and rsp_data=0; the response handshake is otherwise unchanged.
- Writes:
  - Take effect only when state==LOAD && ld_we=1.
  - Each byte i with ld_be[i]=1 is written with ld_wdata[8i+7:8i] at ld_addr+i.
  - A misaligned or out-of-range ld_addr gives no write and pulses ld_err=1 the next cycle.
  - ld_we outside LOAD is ignored silently.
- Read-after-write: a word written in LOAD is returned by the first fetch after returning to FETCH. A held response is never altered by later writes.
- fetch_cnt increments on every accepted request, including errored ones.
- Reset mid-operation discards any pending response and LOAD state. Memory keeps its contents.

Decomposition:
- Package imem_pkg holds:
  - typedef enum {FETCH, DRAIN, LOAD} imem_state_t;
  - the constant MIPS_WORD_BYTES = 4;
  - a function addr_ok(addr, depth, wbytes).
- One sub-module, imem_byte_array: a byte-wide RAM with a WORD_BYTES-wide read port (registered) and a byte-enabled write port. imem_sync holds the FSM, response register, error logic and counter.

Test Plan:
- LOAD, write 0x20100006 at addr 0 with ld_be=4'hF, leave LOAD, fetch addr 0 -> rsp_data=0x20100006 one cycle after accept, rsp_err=0; mem[0]=0x06, mem[3]=0x20.
- Fetch addr 0x2 -> rsp_err=1, rsp_data=0. Fetch addr 1020 -> valid word, rsp_err=0. Fetch addr 1024 -> rsp_err=1.
- Stream fetches at addrs 0, 4, 8 with rsp_ready=1 -> 3 responses on consecutive cycles, fetch_cnt=3. Hold rsp_ready=0 for 4 cycles -> rsp_data stable and req_ready=0.
- Pending response with rsp_ready=0 and ld_req=1 -> DRAIN, ld_ack=0. Raise rsp_ready -> LOAD the next cycle, ld_ack=1.
- In LOAD, write ld_be=4'b0010 with data 0x0000AB00 at addr 4 over 0x11223344 -> later fetch addr 4 returns 0x1122AB44. Write at addr 6 -> ld_err pulse and memory unchanged.
- Assert reset with a response pending -> rsp_valid=0, fetch_cnt=0 next cycle, and a previously loaded word is still readable.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } imem_state_t;

  localparam int MIPS_WORD_BYTES = 4;

  // True when addr is word aligned and a whole word fits below depth (no wrap).
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] depth,
                                   input logic [63:0] wbytes);
    return ((addr % wbytes) == 64'd0) && (wbytes <= depth) &&
           (addr <= depth - wbytes);
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-banked RAM: one bank per byte lane, registered word read port and
// byte-enabled word write port. Bank gi holds byte gi of every word, so an
// aligned word access touches exactly one entry in each bank.
module imem_byte_array #(
  parameter int WORDS      = 256,
  parameter int WORD_BYTES = 4,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [8*WORD_BYTES-1:0] rdata
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bank
    logic [7:0] bank [WORDS];
    logic [7:0] rd_byte_reg;

    // Byte-lane write and registered read for this lane.
    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        bank[waddr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rd_byte_reg <= bank[raddr];
      end
    end

    assign rdata[8*gi +: 8] = rd_byte_reg;
  end

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with valid/ready fetch port, 1-cycle read
// latency, run-time loader (LOAD mode) and a saturating fetch counter.
module imem_sync
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int WORD_BYTES  = MIPS_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_data,
  output logic                    rsp_err,
  input  logic                    ld_req,
  output logic                    ld_ack,
  input  logic                    ld_we,
  input  logic [WORD_BYTES-1:0]   ld_be,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [8*WORD_BYTES-1:0] ld_wdata,
  output logic                    ld_err,
  output logic [31:0]             fetch_cnt
);

  localparam int WORDS = DEPTH_BYTES / WORD_BYTES;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  imem_state_t state_reg, state_next;
  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic        ld_err_reg;
  logic [31:0] fetch_cnt_reg;

  logic                    rsp_free;
  logic                    accept;
  logic                    req_ok;
  logic                    ld_ok;
  logic                    in_load;
  logic                    ram_we;
  logic [IDX_W-1:0]        ram_waddr;
  logic [IDX_W-1:0]        ram_raddr;
  logic [8*WORD_BYTES-1:0] ram_rdata;

  assign rsp_free  = !rsp_valid_reg || rsp_ready;
  assign in_load   = (state_reg == LOAD);
  assign req_ready = (state_reg == FETCH) && rsp_free && !ld_req;
  assign accept    = req_valid && req_ready;

  assign req_ok = addr_ok(64'(req_addr), 64'(DEPTH_BYTES), 64'(WORD_BYTES));
  assign ld_ok  = addr_ok(64'(ld_addr), 64'(DEPTH_BYTES), 64'(WORD_BYTES));

  // Word indices are only used when the address has been range-checked.
  assign ram_raddr = IDX_W'(64'(req_addr) / 64'(WORD_BYTES));
  assign ram_waddr = IDX_W'(64'(ld_addr) / 64'(WORD_BYTES));
  assign ram_we    = in_load && ld_we && ld_ok;

  imem_byte_array #(
    .WORDS     (WORDS),
    .WORD_BYTES(WORD_BYTES),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .be   (ld_be),
    .waddr(ram_waddr),
    .wdata(ld_wdata),
    .re   (accept && req_ok),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Next-state logic: LOAD is entered only once no response is outstanding.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: if (ld_req) state_next = rsp_free ? LOAD : DRAIN;
      DRAIN: begin
        if (!ld_req)       state_next = FETCH;
        else if (rsp_free) state_next = LOAD;
      end
      LOAD:    if (!ld_req) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // State, response flags, loader error pulse and saturating fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      ld_err_reg    <= 1'b0;
      fetch_cnt_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      ld_err_reg <= in_load && ld_we && !ld_ok;
      if (accept) begin
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= !req_ok;
        if (fetch_cnt_reg != 32'hFFFF_FFFF) begin
          fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
        rsp_err_reg   <= 1'b0;
      end
    end
  end

  // The RAM read register holds the word until the next accept; masking keeps
  // errored and idle responses at zero without resetting the RAM output.
  assign rsp_data  = (rsp_valid_reg && !rsp_err_reg) ? ram_rdata : '0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign ld_ack    = in_load;
  assign ld_err    = ld_err_reg;
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: loader writes, fetch handshake, error cases,
// DRAIN/LOAD sequencing and reset with a pending response.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_req;
  logic        ld_ack;
  logic        ld_we;
  logic [3:0]  ld_be;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_err;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  imem_sync #(.DEPTH_BYTES(1024), .ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ld_req   (ld_req),
    .ld_ack   (ld_ack),
    .ld_we    (ld_we),
    .ld_be    (ld_be),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_err   (ld_err),
    .fetch_cnt(fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One loader write; must be in LOAD. Checks the ld_err pulse after the edge.
  task automatic ld_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic exp_err);
    ld_we = 1'b1; ld_addr = a; ld_wdata = d; ld_be = be;
    tick();
    ld_we = 1'b0;
    check($sformatf("ld_err@%0h", a), 32'(ld_err), 32'(exp_err));
  endtask

  // Single fetch with the consumer ready; checks data/err after one cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = a;
    #1;
    check($sformatf("req_ready@%0h", a), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    exp_cnt++;
    check($sformatf("rsp_valid@%0h", a), 32'(rsp_valid), 32'd1);
    check($sformatf("rsp_data@%0h", a), rsp_data, exp_d);
    check($sformatf("rsp_err@%0h", a), 32'(rsp_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_req = 1'b0; ld_we = 1'b0; ld_be = '0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst ld_ack", 32'(ld_ack), 32'd0);
    check("rst fetch_cnt", fetch_cnt, 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);

    // Enter LOAD and program a few words.
    ld_req = 1'b1;
    #1;
    check("req_ready ld_req", 32'(req_ready), 32'd0);
    tick();
    check("ld_ack load", 32'(ld_ack), 32'd1);
    ld_write(32'd0,    32'h2010_0006, 4'hF, 1'b0);
    ld_write(32'd4,    32'h1122_3344, 4'hF, 1'b0);
    ld_write(32'd8,    32'h8C08_0008, 4'hF, 1'b0);
    ld_write(32'd1020, 32'hCAFE_F00D, 4'hF, 1'b0);
    ld_req = 1'b0;
    tick();
    check("ld_ack leave", 32'(ld_ack), 32'd0);

    // Basic fetch and error cases.
    fetch(32'd0,    32'h2010_0006, 1'b0);
    fetch(32'd2,    32'h0000_0000, 1'b1);
    fetch(32'd1020, 32'hCAFE_F00D, 1'b0);
    fetch(32'd1024, 32'h0000_0000, 1'b1);

    // Loader strobe outside LOAD must not write.
    ld_we = 1'b1; ld_addr = 32'd0; ld_wdata = 32'hFFFF_FFFF; ld_be = 4'hF;
    tick();
    ld_we = 1'b0;
    check("ld_err fetch", 32'(ld_err), 32'd0);
    fetch(32'd0, 32'h2010_0006, 1'b0);

    // Stream three back-to-back fetches.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd0;
    tick();
    check("stream d0", rsp_data, 32'h2010_0006);
    req_addr = 32'd4;
    tick();
    check("stream d4", rsp_data, 32'h1122_3344);
    req_addr = 32'd8;
    tick();
    check("stream d8", rsp_data, 32'h8C08_0008);
    exp_cnt += 3;
    check("stream cnt", fetch_cnt, 32'(exp_cnt));

    // Stall the consumer: response held, no new accept.
    rsp_ready = 1'b0; req_addr = 32'd12;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold%0d ready", i), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("hold%0d data", i), rsp_data, 32'h8C08_0008);
      check($sformatf("hold%0d valid", i), 32'(rsp_valid), 32'd1);
    end
    check("hold cnt", fetch_cnt, 32'(exp_cnt));

    // Load request with pending response goes through DRAIN.
    req_valid = 1'b0; ld_req = 1'b1;
    tick();
    check("drain ld_ack", 32'(ld_ack), 32'd0);
    check("drain req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("drain->load ld_ack", 32'(ld_ack), 32'd1);
    check("drain->load rsp_valid", 32'(rsp_valid), 32'd0);

    // Partial byte write and a rejected misaligned write.
    ld_write(32'd4, 32'h0000_AB00, 4'b0010, 1'b0);
    ld_write(32'd6, 32'hDEAD_BEEF, 4'hF, 1'b1);
    tick();
    check("ld_err pulse end", 32'(ld_err), 32'd0);
    ld_req = 1'b0;
    tick();
    fetch(32'd4, 32'h1122_AB44, 1'b0);
    fetch(32'd8, 32'h8C08_0008, 1'b0);
    check("cnt before reset", fetch_cnt, 32'(exp_cnt));

    // Reset with a response pending; memory must survive.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd1020;
    tick();
    req_valid = 1'b0;
    check("pending valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rst fetch_cnt", fetch_cnt, 32'd0);
    fetch(32'd0, 32'h2010_0006, 1'b0);
    check("post rst cnt", fetch_cnt, 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
